floo_eoc_ctrl: RTL and testbench
================================

// Module: floo_eoc_ctrl
// PURPOSE
//   End-of-computation controller for the compute-tile array. Collects per-cluster end_of_sim
//   flags into sticky completion bits, then waits until the NoC has drained (no outstanding
//   transactions toward the memory endpoints), and raises done_o. A cycle watchdog
//   raises timeout_o on hangs. Benches and the host-side control path use it to end a run.
// PARAMETERS
//   NumClusters    32    number of cluster done inputs (one per compute tile)
//   DrainCycles    100   consecutive noc_idle_i cycles required after all clusters finish
//   TimeoutCycles  0     watchdog limit in RUN+DRAIN cycles; 0 disables the watchdog
//   CntWidth       32    width of cycle_cnt_o and of the internal drain/timeout counters
// PORTS
//   clk_i           in   1            clock
//   rst_ni          in   1            asynchronous reset, active low
//   start_i         in   1            arm; sampled only in IDLE
//   clear_i         in   1            return to IDLE from any state, wipe status
//   cluster_mask_i  in   NumClusters  participating clusters; latched on start
//   cluster_done_i  in   NumClusters  per-cluster end-of-compute level/pulse
//   noc_idle_i      in   1            1 = no outstanding NoC/endpoint transactions
//   busy_o          out  1            state is RUN or DRAIN
//   done_o          out  1            state is DONE (sticky until clear_i)
//   timeout_o       out  1            state is TIMEOUT (sticky until clear_i)
//   done_mask_o     out  NumClusters  sticky per-cluster completion bits
//   num_done_o      out  $clog2(NumClusters+1)  popcount of done_mask_o
//   cycle_cnt_o     out  CntWidth     cycles spent in RUN+DRAIN, saturating
// BEHAVIOUR
//   - Reset: state IDLE. All outputs 0. Latched mask 0. Counters 0.
//   - FSM states: IDLE, RUN, DRAIN, DONE, TIMEOUT. All outputs are registered or decoded from state.
//   - IDLE: on start_i, latch cluster_mask_i, clear done_mask/counters, go to RUN next cycle.
//   - RUN: done_mask <= done_mask | (cluster_done_i & mask), every cycle. Bits never fall before clear.
//     Go to DRAIN when (done_mask_next & mask) == mask. The comparison includes the inputs of
//     the current cycle. An all-zero mask goes to DRAIN the cycle after start.
//   - DRAIN: drain_cnt += 1 when noc_idle_i is high; drain_cnt <= 0 when it is low.
//     Go to DONE once max(DrainCycles,1) consecutive idle cycles have been seen. done_o rises
//     the cycle after the last of those idle cycles. cluster_done_i is ignored here.
//   - cycle_cnt increments in every RUN/DRAIN cycle and saturates at 2^CntWidth-1 (no wrap).
//     It holds its value in DONE and TIMEOUT.
//   - Watchdog: if TimeoutCycles != 0 and cycle_cnt == TimeoutCycles-1 in RUN/DRAIN, go to TIMEOUT.
//     Timeout wins over a completion or drain-exit in the same cycle.
//   - DONE/TIMEOUT: hold. done_mask_o and cycle_cnt_o stay frozen for readout.
//   - clear_i: from any state, go to IDLE next cycle and zero mask, done_mask and counters.
//     clear_i has priority over start_i. start_i outside IDLE is ignored.
//   - Reset asserted mid-run aborts immediately to IDLE. No partial status survives.
//   - num_done_o is combinational popcount of registered done_mask_o.
// TESTING
//   1. mask=all 1s; pulse done bits 0..31 one per cycle; noc_idle_i=1 -> DRAIN after bit 31.
//      DrainCycles=100: done_o rises 100 cycles after DRAIN entry; num_done_o=32.
//   2. mask=0x0000_000F; done on bits 0..3 plus spurious bit 8 -> done_mask_o=0x0000_000F.
//      Bit 8 is not recorded.
//   3. In DRAIN, drop noc_idle_i for 1 cycle at idle count 50 -> counter restarts.
//      done_o comes 100 idle cycles after noc_idle_i returns high.
//   4. TimeoutCycles=1000; bit 5 never finishes -> timeout_o=1 with cycle_cnt_o=1000.
//      done_mask_o bit5=0, done_o=0.
//   5. Last done bit and timeout hit in the same cycle -> TIMEOUT, not DRAIN.
//      Then clear_i -> IDLE, all outputs 0.
//   6. Assert rst_ni low mid-DRAIN, then start again with mask=0 -> DRAIN next cycle.
//      DrainCycles=0 and noc_idle_i=1: done_o 1 cycle later.

Source files
------------

// File: rtl/floo_eoc_ctrl.sv
// End-of-computation controller: gathers sticky per-cluster completion flags, waits for
// the NoC to drain for a run of idle cycles, then reports DONE, with an optional watchdog.
module floo_eoc_ctrl #(
  parameter int unsigned NumClusters   = 32,
  parameter int unsigned DrainCycles   = 100,
  parameter int unsigned TimeoutCycles = 0,
  parameter int unsigned CntWidth      = 32,
  localparam int unsigned NdWidth      = $clog2(NumClusters + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic [NumClusters-1:0] cluster_mask_i,
  input  logic [NumClusters-1:0] cluster_done_i,
  input  logic                   noc_idle_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic [NumClusters-1:0] done_mask_o,
  output logic [NdWidth-1:0]     num_done_o,
  output logic [CntWidth-1:0]    cycle_cnt_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DRAIN   = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_e;

  // A DrainCycles of 0 still needs one idle cycle observed before DONE.
  localparam int unsigned DrainLim = (DrainCycles == 0) ? 1 : DrainCycles;
  localparam logic [CntWidth-1:0] DrainLast   = CntWidth'(DrainLim - 1);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);

  state_e                 state_q, state_d;
  logic [NumClusters-1:0] mask_q, mask_d;
  logic [NumClusters-1:0] done_mask_q, done_mask_d;
  logic [CntWidth-1:0]    drain_cnt_q, drain_cnt_d;
  logic [CntWidth-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [CntWidth-1:0]    cycle_cnt_inc;
  logic                   timeout_hit;

  assign cycle_cnt_inc = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CntWidth'(1);
  assign timeout_hit   = (TimeoutCycles != 0) && (cycle_cnt_q == TimeoutLast);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    done_mask_d = done_mask_q;
    drain_cnt_d = drain_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    if (clear_i) begin
      state_d     = IDLE;
      mask_d      = '0;
      done_mask_d = '0;
      drain_cnt_d = '0;
      cycle_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d     = RUN;
            mask_d      = cluster_mask_i;
            done_mask_d = '0;
            drain_cnt_d = '0;
            cycle_cnt_d = '0;
          end
        end
        RUN: begin
          done_mask_d = done_mask_q | (cluster_done_i & mask_q);
          cycle_cnt_d = cycle_cnt_inc;
          drain_cnt_d = '0;
          // The watchdog outranks a completion landing in the same cycle.
          if (timeout_hit) begin
            state_d = TIMEOUT;
          end else if ((done_mask_d & mask_q) == mask_q) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          cycle_cnt_d = cycle_cnt_inc;
          drain_cnt_d = noc_idle_i ? drain_cnt_q + CntWidth'(1) : '0;
          if (timeout_hit) begin
            state_d = TIMEOUT;
          end else if (noc_idle_i && (drain_cnt_q >= DrainLast)) begin
            state_d = DONE;
          end
        end
        DONE, TIMEOUT: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      done_mask_q <= '0;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      done_mask_q <= done_mask_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  always_comb begin
    num_done_o = '0;
    for (int i = 0; i < NumClusters; i++) begin
      num_done_o = num_done_o + NdWidth'(done_mask_q[i]);
    end
  end

  assign busy_o      = (state_q == RUN) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE);
  assign timeout_o   = (state_q == TIMEOUT);
  assign done_mask_o = done_mask_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_floo_eoc_ctrl.sv
// Directed bench for floo_eoc_ctrl: one instance with a 1000-cycle watchdog and one with
// DrainCycles=0, checked through an expected-value queue.
module tb_floo_eoc_ctrl;

  logic        clk;
  logic        rst_n;

  logic        start_a, clear_a, idle_a;
  logic [31:0] mask_a, cdone_a;
  logic        busy_a, done_a, to_a;
  logic [31:0] dmask_a, cnt_a;
  logic [5:0]  num_a;

  logic        start_b, clear_b, idle_b;
  logic [31:0] mask_b, cdone_b;
  logic        busy_b, done_b, to_b;
  logic [31:0] dmask_b, cnt_b;
  logic [5:0]  num_b;

  floo_eoc_ctrl #(
    .NumClusters(32), .DrainCycles(100), .TimeoutCycles(1000), .CntWidth(32)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .clear_i(clear_a),
    .cluster_mask_i(mask_a), .cluster_done_i(cdone_a), .noc_idle_i(idle_a),
    .busy_o(busy_a), .done_o(done_a), .timeout_o(to_a),
    .done_mask_o(dmask_a), .num_done_o(num_a), .cycle_cnt_o(cnt_a)
  );

  floo_eoc_ctrl #(
    .NumClusters(32), .DrainCycles(0), .TimeoutCycles(0), .CntWidth(32)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .clear_i(clear_b),
    .cluster_mask_i(mask_b), .cluster_done_i(cdone_b), .noc_idle_i(idle_b),
    .busy_o(busy_b), .done_o(done_b), .timeout_o(to_b),
    .done_mask_o(dmask_b), .num_done_o(num_b), .cycle_cnt_o(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic check_next(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL sb_empty observed=%0h required=<queued value>", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.val)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue the full A-side status, then compare it in the same order.
  task automatic check_a(input string tag, input logic busy, input logic done, input logic to,
                         input logic [31:0] dmask, input logic [5:0] num, input logic [31:0] cnt);
    expect_val({tag, "_busy"}, 64'(busy));
    expect_val({tag, "_done"}, 64'(done));
    expect_val({tag, "_timeout"}, 64'(to));
    expect_val({tag, "_done_mask"}, 64'(dmask));
    expect_val({tag, "_num_done"}, 64'(num));
    expect_val({tag, "_cycle_cnt"}, 64'(cnt));
    check_next(64'(busy_a));
    check_next(64'(done_a));
    check_next(64'(to_a));
    check_next(64'(dmask_a));
    check_next(64'(num_a));
    check_next(64'(cnt_a));
  endtask

  task automatic clear_pulse_a;
    clear_a = 1'b1;
    tick(1);
    clear_a = 1'b0;
  endtask

  task automatic start_a_with(input logic [31:0] m);
    mask_a  = m;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    start_a = 1'b0; clear_a = 1'b0; idle_a = 1'b0; mask_a = '0; cdone_a = '0;
    start_b = 1'b0; clear_b = 1'b0; idle_b = 1'b0; mask_b = '0; cdone_b = '0;
    tick(3);
    check_a("reset", 1'b0, 1'b0, 1'b0, 32'h0, 6'd0, 32'd0);
    rst_n = 1'b1;
    tick(2);
    check_a("idle_after_reset", 1'b0, 1'b0, 1'b0, 32'h0, 6'd0, 32'd0);

    // 1: all clusters, one done bit per cycle, then 100 idle drain cycles.
    idle_a = 1'b1;
    start_a_with(32'hFFFF_FFFF);
    check_a("t1_run", 1'b1, 1'b0, 1'b0, 32'h0, 6'd0, 32'd0);
    for (int i = 0; i < 32; i++) begin
      cdone_a = 32'h1 << i;
      tick(1);
    end
    cdone_a = '0;
    check_a("t1_drain_entry", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 6'd32, 32'd32);
    n = 0;
    while (!done_a && n < 300) begin
      tick(1);
      n++;
    end
    expect_val("t1_drain_latency", 64'd100);
    check_next(64'(n));
    check_a("t1_done", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 6'd32, 32'd132);
    tick(3);
    check_a("t1_done_hold", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 6'd32, 32'd132);
    start_a_with(32'h0);
    check_a("t1_start_ignored", 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 6'd32, 32'd132);
    clear_pulse_a();
    check_a("t1_clear", 1'b0, 1'b0, 1'b0, 32'h0, 6'd0, 32'd0);

    // 2: spurious done on an unmasked cluster is not recorded.
    start_a_with(32'h0000_000F);
    cdone_a = 32'h0000_0103;
    tick(1);
    check_a("t2_partial", 1'b1, 1'b0, 1'b0, 32'h0000_0003, 6'd2, 32'd1);
    cdone_a = 32'h0000_010C;
    tick(1);
    cdone_a = '0;
    check_a("t2_complete", 1'b1, 1'b0, 1'b0, 32'h0000_000F, 6'd4, 32'd2);
    clear_pulse_a();

    // 3: one non-idle cycle mid-drain restarts the idle count.
    start_a_with(32'h0000_0001);
    cdone_a = 32'h1;
    tick(1);
    cdone_a = '0;
    tick(50);
    idle_a = 1'b0;
    tick(1);
    idle_a = 1'b1;
    expect_val("t3_not_done_after_drop", 64'd0);
    check_next(64'(done_a));
    n = 0;
    while (!done_a && n < 300) begin
      tick(1);
      n++;
    end
    expect_val("t3_drain_restart_latency", 64'd100);
    check_next(64'(n));
    clear_pulse_a();

    // 4: cluster 5 never finishes; watchdog fires at 1000 cycles.
    start_a_with(32'hFFFF_FFFF);
    cdone_a = ~(32'h1 << 5);
    n = 0;
    while (!to_a && n < 1100) begin
      tick(1);
      n++;
    end
    cdone_a = '0;
    expect_val("t4_timeout_latency", 64'd1000);
    check_next(64'(n));
    check_a("t4_timeout", 1'b0, 1'b0, 1'b1, ~(32'h1 << 5), 6'd31, 32'd1000);
    tick(5);
    check_a("t4_frozen", 1'b0, 1'b0, 1'b1, ~(32'h1 << 5), 6'd31, 32'd1000);
    clear_pulse_a();

    // 5: last done bit arrives in the same cycle the watchdog expires.
    start_a_with(32'hFFFF_FFFF);
    cdone_a = ~(32'h1 << 5);
    tick(999);
    expect_val("t5_still_running", 64'd1);
    check_next(64'(busy_a));
    cdone_a = 32'hFFFF_FFFF;
    tick(1);
    cdone_a = '0;
    expect_val("t5_timeout_wins", 64'd1);
    check_next(64'(to_a));
    expect_val("t5_no_drain", 64'd0);
    check_next(64'(busy_a));
    expect_val("t5_cycle_cnt", 64'd1000);
    check_next(64'(cnt_a));
    clear_a = 1'b1;
    start_a = 1'b1;
    mask_a  = 32'hFFFF_FFFF;
    tick(1);
    clear_a = 1'b0;
    start_a = 1'b0;
    check_a("t5_clear", 1'b0, 1'b0, 1'b0, 32'h0, 6'd0, 32'd0);

    // 6: asynchronous reset mid-drain on the DrainCycles=0 instance, then restart.
    idle_b  = 1'b0;
    mask_b  = 32'h1;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    cdone_b = 32'h1;
    tick(1);
    cdone_b = '0;
    tick(2);
    expect_val("t6_in_drain_busy", 64'd1);
    check_next(64'(busy_b));
    expect_val("t6_in_drain_mask", 64'd1);
    check_next(64'(dmask_b));
    #2 rst_n = 1'b0;
    #1;
    expect_val("t6_async_busy", 64'd0);
    check_next(64'(busy_b));
    expect_val("t6_async_mask", 64'd0);
    check_next(64'(dmask_b));
    expect_val("t6_async_cnt", 64'd0);
    check_next(64'(cnt_b));
    tick(2);
    rst_n = 1'b1;
    tick(1);
    idle_b  = 1'b1;
    mask_b  = 32'h0;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    expect_val("t6_run_busy", 64'd1);
    check_next(64'(busy_b));
    tick(1);
    expect_val("t6_drain_not_done", 64'd0);
    check_next(64'(done_b));
    expect_val("t6_drain_busy", 64'd1);
    check_next(64'(busy_b));
    tick(1);
    expect_val("t6_done", 64'd1);
    check_next(64'(done_b));
    expect_val("t6_cycle_cnt", 64'd2);
    check_next(64'(cnt_b));
    expect_val("t6_num_done", 64'd0);
    check_next(64'(num_b));
    expect_val("t6_no_timeout", 64'd0);
    check_next(64'(to_b));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
